data_memory_ctrl: RTL and testbench

//   Parametrised MIPS32 data memory with a valid/ready request port and a response port.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_bank.sv | 41 ++++
 rtl/data_memory_ctrl.sv | 157 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the MIPS32 data memory controller.
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   function automatic logic [3:0] be_gen(input logic [1:0] lo, input logic [1:0] size);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << lo;
         SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lo,
                                            input logic [1:0] size, input logic sgn);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lo, 3'b000};
      case (size)
         SIZE_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
         SIZE_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
         SIZE_WORD: res = word;
         default:   res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide RAM bank with per-byte write enables; read data registered on re and held otherwise.
// One access per cycle (read or write); rdata valid the cycle after re.
module dmem_bank #(
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   // Holding rdata lets a multi-cycle load response read it without re-accessing the array.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[addr];
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// MIPS32 data memory: GLOBAL/STACK regions on two banks; stores answer next cycle, loads after READ_LAT.
// req_ready drops while a multi-cycle load (or errored load) is outstanding so responses stay in order.
module data_memory_ctrl #(
   parameter int                DEPTH       = 256,
   parameter int                ADDR_W      = 12,
   parameter logic [ADDR_W-1:0] GLOBAL_BASE = 'h000,
   parameter logic [ADDR_W-1:0] STACK_BASE  = 'h400,
   parameter int                READ_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);
   import dmem_pkg::*;

   localparam int         REG_W    = $clog2(4 * DEPTH);
   localparam logic [1:0] LAT_LAST = 2'((READ_LAT > 1) ? READ_LAT - 2 : 0);
   localparam logic [1:0] LAT_ERR  = 2'(READ_LAT - 1);

   logic             hit_g, hit_s, misalign, req_err, acc;
   logic [REG_W-3:0] widx;
   logic [3:0]       be;
   logic [31:0]      wdata_rep, g_rdata, s_rdata;
   logic             g_we, g_re, s_we, s_re;

   logic [0:0] state_q, state_d;
   logic [1:0] lat_cnt_q, lat_cnt_d, err_cnt_q, err_cnt_d;
   logic       ready_q, ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic       pend_ok_q, pend_ok_d, pend_stack_q, pend_stack_d, pend_sgn_q, pend_sgn_d;
   logic [1:0] pend_lo_q, pend_lo_d, pend_size_q, pend_size_d;

   assign hit_g    = (req_addr[ADDR_W-1:REG_W] == GLOBAL_BASE[ADDR_W-1:REG_W]);
   assign hit_s    = (req_addr[ADDR_W-1:REG_W] == STACK_BASE[ADDR_W-1:REG_W]);
   assign misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                     ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
   assign req_err  = misalign || (req_size == SIZE_RSVD) || !(hit_g || hit_s);
   assign acc      = req_valid && ready_q;
   assign widx     = req_addr[REG_W-1:2];
   assign be       = be_gen(req_addr[1:0], req_size);

   always_comb begin
      case (req_size)
         SIZE_BYTE: wdata_rep = {4{req_wdata[7:0]}};
         SIZE_HALF: wdata_rep = {2{req_wdata[15:0]}};
         default:   wdata_rep = req_wdata;
      endcase
   end

   assign g_we = acc && req_write && !req_err && hit_g;
   assign g_re = acc && !req_write && !req_err && hit_g;
   assign s_we = acc && req_write && !req_err && hit_s;
   assign s_re = acc && !req_write && !req_err && hit_s;

   dmem_bank #(.DEPTH(DEPTH)) u_global (
      .clk(clk), .we(g_we), .re(g_re), .be(be), .addr(widx), .wdata(wdata_rep), .rdata(g_rdata)
   );

   dmem_bank #(.DEPTH(DEPTH)) u_stack (
      .clk(clk), .we(s_we), .re(s_re), .be(be), .addr(widx), .wdata(wdata_rep), .rdata(s_rdata)
   );

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      err_cnt_d    = err_cnt_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      pend_ok_d    = pend_ok_q;
      pend_stack_d = pend_stack_q;
      pend_sgn_d   = pend_sgn_q;
      pend_lo_d    = pend_lo_q;
      pend_size_d  = pend_size_q;
      case (state_q)
         ST_IDLE: begin
            if (acc) begin
               pend_ok_d    = !req_write && !req_err;
               pend_stack_d = hit_s;
               pend_sgn_d   = req_signed;
               pend_lo_d    = req_addr[1:0];
               pend_size_d  = req_size;
               if (req_write || (READ_LAT == 1)) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = req_err;
               end else if (req_err) begin
                  err_cnt_d = LAT_ERR;
               end else begin
                  state_d   = ST_WAIT;
                  lat_cnt_d = 2'd0;
               end
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Errored loads keep the FSM in IDLE but still take the load latency.
      if (err_cnt_q != 2'd0) begin
         err_cnt_d = err_cnt_q - 2'd1;
         if (err_cnt_q == 2'd1) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
         end
      end
      ready_d = (state_d == ST_IDLE) && (err_cnt_d == 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         lat_cnt_q    <= 2'd0;
         err_cnt_q    <= 2'd0;
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         pend_ok_q    <= 1'b0;
         pend_stack_q <= 1'b0;
         pend_sgn_q   <= 1'b0;
         pend_lo_q    <= 2'd0;
         pend_size_q  <= 2'd0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         err_cnt_q    <= err_cnt_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         pend_ok_q    <= pend_ok_d;
         pend_stack_q <= pend_stack_d;
         pend_sgn_q   <= pend_sgn_d;
         pend_lo_q    <= pend_lo_d;
         pend_size_q  <= pend_size_d;
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = (resp_valid_q && pend_ok_q)
                     ? load_ext(pend_stack_q ? s_rdata : g_rdata, pend_lo_q, pend_size_q, pend_sgn_q)
                     : 32'd0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: READ_LAT=1 (index 0) and READ_LAT=3 (index 1) instances, scoreboard-checked.
module tb_data_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid [2];
   logic        req_write [2];
   logic        req_signed[2];
   logic [11:0] req_addr  [2];
   logic [1:0]  req_size  [2];
   logic [31:0] req_wdata [2];
   logic        req_ready [2];
   logic        resp_valid[2];
   logic        resp_err  [2];
   logic [31:0] resp_rdata[2];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_ctrl #(.READ_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
      .req_signed(req_signed[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   data_memory_ctrl #(.READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
      .req_signed(req_signed[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   // Response monitor: every resp_valid must match the oldest expectation, including its cycle.
   always @(negedge clk) begin
      for (int w = 0; w < 2; w++) begin
         exp_t e;
         if (resp_valid[w] === 1'b1) begin
            checks++;
            if ((w == 0 ? sb0.size() : sb1.size()) == 0) begin
               errors++;
               $display("FAIL resp_unexpected dut%0d cyc %0d: got rdata %h err %b, required no response",
                        w, cyc, resp_rdata[w], resp_err[w]);
            end else begin
               if (w == 0) e = sb0.pop_front();
               else        e = sb1.pop_front();
               if (resp_rdata[w] !== e.rdata || resp_err[w] !== e.err || cyc != e.due) begin
                  errors++;
                  $display("FAIL resp dut%0d: got rdata %h err %b cyc %0d, required rdata %h err %b cyc %0d",
                           w, resp_rdata[w], resp_err[w], cyc, e.rdata, e.err, e.due);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic issue(input int w, input logic wr, input logic [11:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd, input logic [31:0] er, input logic ee);
      int   n = 0;
      exp_t e;
      req_valid[w]  = 1'b1;
      req_write[w]  = wr;
      req_addr[w]   = a;
      req_size[w]   = sz;
      req_signed[w] = sg;
      req_wdata[w]  = wd;
      while (req_ready[w] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready[w] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout dut%0d addr %h: got req_ready %b, required 1", w, a, req_ready[w]);
      end else begin
         e.rdata = er;
         e.err   = ee;
         e.due   = cyc + ((wr || w == 0) ? 1 : 3);
         if (w == 0) sb0.push_back(e);
         else        sb1.push_back(e);
      end
      @(negedge clk);
      req_valid[w] = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb0.size() + sb1.size()) != 0 && n < 30) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if ((sb0.size() + sb1.size()) != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", sb0.size(), sb1.size());
         sb0.delete();
         sb1.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (req_ready[w] !== 1'b0 || resp_valid[w] !== 1'b0 || resp_err[w] !== 1'b0 ||
             resp_rdata[w] !== 32'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got ready %b valid %b err %b rdata %h, required 0 0 0 0",
                     w, req_ready[w], resp_valid[w], resp_err[w], resp_rdata[w]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (req_ready[w] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset dut%0d: got %b, required 1", w, req_ready[w]);
         end
      end
   endtask

   task automatic test_word(input int w);
      issue(w, 1'b1, 12'h004, 2'b10, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0);
      issue(w, 1'b0, 12'h004, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0);
      wait_drain();
   endtask

   task automatic test_byte(input int w);
      issue(w, 1'b1, 12'h005, 2'b00, 1'b0, 32'hAAAAAA7F, 32'd0, 1'b0);
      issue(w, 1'b0, 12'h005, 2'b00, 1'b1, 32'd0, 32'h0000007F, 1'b0);
      issue(w, 1'b1, 12'h006, 2'b00, 1'b0, 32'h12345680, 32'd0, 1'b0);
      issue(w, 1'b0, 12'h006, 2'b00, 1'b1, 32'd0, 32'hFFFFFF80, 1'b0);
      issue(w, 1'b0, 12'h006, 2'b00, 1'b0, 32'd0, 32'h00000080, 1'b0);
      issue(w, 1'b0, 12'h004, 2'b10, 1'b0, 32'd0, 32'hDE807FEF, 1'b0);
      wait_drain();
   endtask

   task automatic test_half_stack(input int w);
      issue(w, 1'b1, 12'h400, 2'b10, 1'b0, 32'h12345678, 32'd0, 1'b0);
      issue(w, 1'b1, 12'h402, 2'b01, 1'b0, 32'h55558001, 32'd0, 1'b0);
      issue(w, 1'b0, 12'h402, 2'b01, 1'b1, 32'd0, 32'hFFFF8001, 1'b0);
      issue(w, 1'b0, 12'h402, 2'b01, 1'b0, 32'd0, 32'h00008001, 1'b0);
      issue(w, 1'b0, 12'h400, 2'b10, 1'b0, 32'd0, 32'h80015678, 1'b0);
      wait_drain();
   endtask

   task automatic test_errors(input int w);
      issue(w, 1'b1, 12'h000, 2'b10, 1'b0, 32'h11223344, 32'd0, 1'b0);
      issue(w, 1'b0, 12'h002, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1);
      issue(w, 1'b1, 12'h001, 2'b01, 1'b0, 32'h00009999, 32'd0, 1'b1);
      issue(w, 1'b0, 12'h000, 2'b11, 1'b0, 32'd0, 32'd0, 1'b1);
      issue(w, 1'b0, 12'h800, 2'b10, 1'b0, 32'd0, 32'd0, 1'b1);
      issue(w, 1'b1, 12'h800, 2'b10, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1);
      issue(w, 1'b1, 12'h002, 2'b10, 1'b0, 32'hCAFEF00D, 32'd0, 1'b1);
      issue(w, 1'b0, 12'h000, 2'b10, 1'b0, 32'd0, 32'h11223344, 1'b0);
      issue(w, 1'b0, 12'h002, 2'b01, 1'b0, 32'd0, 32'h00001122, 1'b0);
      issue(w, 1'b0, 12'h003, 2'b00, 1'b0, 32'd0, 32'h00000011, 1'b0);
      wait_drain();
   endtask

   task automatic test_back_to_back(input int w);
      int t0;
      t0 = cyc;
      issue(w, 1'b1, 12'h008, 2'b10, 1'b0, 32'hAABBCCDD, 32'd0, 1'b0);
      issue(w, 1'b1, 12'h00C, 2'b10, 1'b0, 32'h01020304, 32'd0, 1'b0);
      issue(w, 1'b1, 12'h010, 2'b10, 1'b0, 32'h0BADF00D, 32'd0, 1'b0);
      checks++;
      if (cyc - t0 != 3) begin
         errors++;
         $display("FAIL store_rate dut%0d: got %0d cycles for 3 stores, required 3", w, cyc - t0);
      end
      issue(w, 1'b1, 12'h008, 2'b10, 1'b0, 32'h5EED1234, 32'd0, 1'b0);
      issue(w, 1'b0, 12'h008, 2'b10, 1'b0, 32'd0, 32'h5EED1234, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         logic want;
         want = (w == 0 || i == 3) ? 1'b1 : 1'b0;
         checks++;
         if (req_ready[w] !== want) begin
            errors++;
            $display("FAIL ready_pattern dut%0d cycle T+%0d: got %b, required %b", w, i, req_ready[w], want);
         end
         if (i < 3) @(negedge clk);
      end
      wait_drain();
      t0 = cyc;
      issue(w, 1'b0, 12'h00C, 2'b10, 1'b0, 32'd0, 32'h01020304, 1'b0);
      issue(w, 1'b0, 12'h010, 2'b10, 1'b0, 32'd0, 32'h0BADF00D, 1'b0);
      issue(w, 1'b0, 12'h011, 2'b00, 1'b0, 32'd0, 32'h000000F0, 1'b0);
      issue(w, 1'b0, 12'h012, 2'b01, 1'b0, 32'd0, 32'h00000BAD, 1'b0);
      checks++;
      if (cyc - t0 != (w == 0 ? 4 : 10)) begin
         errors++;
         $display("FAIL load_rate dut%0d: got %0d cycles for 4 loads, required %0d",
                  w, cyc - t0, (w == 0 ? 4 : 10));
      end
      wait_drain();
   endtask

   task automatic test_reset_mid_load();
      req_valid[1] = 1'b1;
      req_write[1] = 1'b0;
      req_addr[1]  = 12'h004;
      req_size[1]  = 2'b10;
      @(negedge clk);
      req_valid[1] = 1'b0;
      rst          = 1'b1;
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 12'h014;
      req_size[0]  = 2'b10;
      req_wdata[0] = 32'h5A5A5A5A;
      @(negedge clk);
      req_valid[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (resp_valid[1] !== 1'b0 || (i < 2 && req_ready[1] !== 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_load step %0d: got valid %b ready %b, required valid 0 ready %0d",
                     i, resp_valid[1], req_ready[1], (i < 2) ? 0 : 1);
         end
         if (i == 1) rst = 1'b0;
         @(negedge clk);
      end
      issue(1, 1'b0, 12'h004, 2'b10, 1'b0, 32'd0, 32'hDE807FEF, 1'b0);
      issue(0, 1'b0, 12'h014, 2'b10, 1'b0, 32'd0, 32'h5A5A5A5A, 1'b0);
      wait_drain();
   endtask

   initial begin
      for (int w = 0; w < 2; w++) begin
         req_valid[w]  = 1'b0;
         req_write[w]  = 1'b0;
         req_signed[w] = 1'b0;
         req_addr[w]   = 12'h000;
         req_size[w]   = 2'b00;
         req_wdata[w]  = 32'd0;
      end
      test_reset();
      for (int w = 0; w < 2; w++) begin
         test_word(w);
         test_byte(w);
         test_half_stack(w);
         test_errors(w);
         test_back_to_back(w);
      end
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
